// File: rtl/ps2_pkg.sv
// Shared types and width helpers for the PS/2 packet framer.
package ps2_pkg;

    typedef enum logic {
        SEARCH  = 1'b0,
        COLLECT = 1'b1
    } state_t;

    // Byte index width: idx only ever holds 0..pkt_bytes-1, and pkt_bytes is at least 2.
    function automatic int idx_width(input int pkt_bytes);
        return $clog2(pkt_bytes);
    endfunction

    // Idle counter width: must hold 0..timeout. Kept at 1 bit or more so TIMEOUT=0 still elaborates.
    function automatic int to_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/ps2_packet_framer_sat_counter.sv
// Saturating up-counter: q steps by one on each inc and holds at all-ones.
// Registered output, one-cycle update latency, no backpressure.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            q <= '0;
        else if (inc && (q != '1))
            q <= q + W'(1);
    end

endmodule

// File: rtl/ps2_packet_framer.sv
// Frames a valid-qualified byte stream into PKT_BYTES-byte packets on a sync bit, aborting stalled packets.
// done/out_bytes register one cycle after the last byte; there is no backpressure, and bytes with in_valid=0 are ignored.
module ps2_packet_framer
    import ps2_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int PKT_BYTES = 3,
    parameter int SYNC_BIT  = 3,
    parameter int TIMEOUT   = 16,
    parameter int ERR_W     = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DATA_W-1:0]           in,
    input  logic                        in_valid,
    output logic [PKT_BYTES*DATA_W-1:0] out_bytes,
    output logic                        done,
    output logic                        timeout_err,
    output logic [ERR_W-1:0]            err_cnt
);

    localparam int IDX_W = idx_width(PKT_BYTES);
    localparam int TO_W  = to_width(TIMEOUT);
    localparam int SH_W  = (PKT_BYTES - 1) * DATA_W;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PKT_BYTES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t                        state, state_nxt;
    logic [IDX_W-1:0]              idx, idx_nxt;
    logic [TO_W-1:0]               idle, idle_nxt;
    logic [SH_W-1:0]               shreg, shreg_nxt;
    logic [PKT_BYTES*DATA_W-1:0]   out_nxt;
    logic                          done_nxt;
    logic                          abort;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= SEARCH;
            idx         <= '0;
            idle        <= '0;
            shreg       <= '0;
            out_bytes   <= '0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            idle        <= idle_nxt;
            shreg       <= shreg_nxt;
            out_bytes   <= out_nxt;
            done        <= done_nxt;
            timeout_err <= abort;
        end
    end

    // shreg holds the bytes collected so far, oldest in the MSBs; the last byte is appended straight into out_bytes.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        idle_nxt  = idle;
        shreg_nxt = shreg;
        out_nxt   = out_bytes;
        done_nxt  = 1'b0;
        abort     = 1'b0;

        case (state)
            SEARCH: begin
                idle_nxt = '0;
                if (in_valid && in[SYNC_BIT]) begin
                    shreg_nxt = SH_W'(in);
                    idx_nxt   = IDX_W'(1);
                    state_nxt = COLLECT;
                end
            end
            COLLECT: begin
                if (in_valid) begin
                    // An arriving byte always beats an expiring idle count.
                    idle_nxt = '0;
                    if (idx == IDX_LAST) begin
                        out_nxt   = {shreg, in};
                        done_nxt  = 1'b1;
                        idx_nxt   = '0;
                        state_nxt = SEARCH;
                    end else begin
                        shreg_nxt = SH_W'({shreg, in});
                        idx_nxt   = idx + IDX_W'(1);
                    end
                end else if (TIMEOUT > 0) begin
                    if (idle == TO_LAST) begin
                        abort     = 1'b1;
                        idle_nxt  = '0;
                        idx_nxt   = '0;
                        state_nxt = SEARCH;
                    end else begin
                        idle_nxt = idle + TO_W'(1);
                    end
                end
            end
            default: state_nxt = SEARCH;
        endcase
    end

    sat_counter #(
        .W(ERR_W)
    ) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (abort),
        .q     (err_cnt)
    );

endmodule

// File: tb/tb_ps2_packet_framer.sv
// Scoreboard bench: three framer configurations (default, ERR_W=2, PKT_BYTES=4) driven by directed byte sequences.
module tb_ps2_packet_framer;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  in_b [3];
    logic        vld  [3];
    logic [23:0] ob0, ob1;
    logic [31:0] ob2;
    logic        dn0, dn1, dn2, te0, te1, te2;
    logic [7:0]  ec0, ec2;
    logic [1:0]  ec1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int          cyc;
        logic [31:0] val;
    } exp_t;

    exp_t dq [3][$];
    exp_t eq [3][$];

    always @(posedge clk) cyc <= cyc + 1;

    ps2_packet_framer #(.DATA_W(8), .PKT_BYTES(3), .SYNC_BIT(3), .TIMEOUT(16), .ERR_W(8)) u_d0 (
        .clk(clk), .reset(reset), .in(in_b[0]), .in_valid(vld[0]),
        .out_bytes(ob0), .done(dn0), .timeout_err(te0), .err_cnt(ec0));

    ps2_packet_framer #(.DATA_W(8), .PKT_BYTES(3), .SYNC_BIT(3), .TIMEOUT(16), .ERR_W(2)) u_d1 (
        .clk(clk), .reset(reset), .in(in_b[1]), .in_valid(vld[1]),
        .out_bytes(ob1), .done(dn1), .timeout_err(te1), .err_cnt(ec1));

    ps2_packet_framer #(.DATA_W(8), .PKT_BYTES(4), .SYNC_BIT(3), .TIMEOUT(16), .ERR_W(8)) u_d2 (
        .clk(clk), .reset(reset), .in(in_b[2]), .in_valid(vld[2]),
        .out_bytes(ob2), .done(dn2), .timeout_err(te2), .err_cnt(ec2));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic send(input int k, input logic [7:0] b, output int ecyc);
        in_b[k] = b;
        vld[k]  = 1'b1;
        @(posedge clk);
        #1;
        ecyc = cyc;
    endtask

    task automatic idle(input int k, input int n);
        vld[k] = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_done(input int k, input int c, input logic [31:0] v);
        dq[k].push_back('{cyc: c, val: v});
    endtask

    task automatic push_err(input int k, input int c, input logic [31:0] v);
        eq[k].push_back('{cyc: c, val: v});
    endtask

    // Monitor: every done/timeout_err pulse must match the next scoreboard entry, cycle included.
    always @(negedge clk) begin : mon
        logic [31:0] obv [3];
        logic [31:0] ecv [3];
        logic        dn  [3];
        logic        te  [3];
        exp_t        e;
        obv[0] = {8'h00, ob0}; obv[1] = {8'h00, ob1}; obv[2] = ob2;
        ecv[0] = {24'h0, ec0}; ecv[1] = {30'h0, ec1}; ecv[2] = {24'h0, ec2};
        dn[0] = dn0; dn[1] = dn1; dn[2] = dn2;
        te[0] = te0; te[1] = te1; te[2] = te2;
        for (int k = 0; k < 3; k++) begin
            if (dn[k] || te[k])
                chk($sformatf("exclusive%0d", k), {63'h0, dn[k] & te[k]}, 64'h0);
            if (dn[k]) begin
                if (dq[k].size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_done%0d actual=%h required=none", k, obv[k]);
                end else begin
                    e = dq[k].pop_front();
                    chk($sformatf("done%0d(cyc,out)", k), {cyc, obv[k]}, {e.cyc, e.val});
                end
            end
            if (te[k]) begin
                if (eq[k].size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_timeout%0d actual=%h required=none", k, ecv[k]);
                end else begin
                    e = eq[k].pop_front();
                    chk($sformatf("timeout%0d(cyc,cnt)", k), {cyc, ecv[k]}, {e.cyc, e.val});
                end
            end
        end
    end

    initial begin
        int c;
        int exp_e [5];
        logic [7:0] noise [5];
        exp_e = '{1, 2, 3, 3, 3};
        noise = '{8'h00, 8'h11, 8'h22, 8'h37, 8'h40};
        for (int k = 0; k < 3; k++) begin
            in_b[k] = 8'h00;
            vld[k]  = 1'b0;
        end

        // reset state
        reset = 1'b1;
        #2;
        chk("rst_out0", {40'h0, ob0}, 64'h0);
        chk("rst_done0", {63'h0, dn0}, 64'h0);
        chk("rst_terr0", {63'h0, te0}, 64'h0);
        chk("rst_cnt0", {56'h0, ec0}, 64'h0);
        chk("rst_out2", {32'h0, ob2}, 64'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        // 1: leading non-sync byte dropped
        send(0, 8'h00, c); send(0, 8'h08, c); send(0, 8'h11, c); send(0, 8'h22, c);
        push_done(0, c, 32'h081122);
        idle(0, 2);

        // 2: back-to-back packets, done 3 cycles apart
        send(0, 8'h08, c); send(0, 8'h01, c); send(0, 8'h02, c);
        push_done(0, c, 32'h080102);
        send(0, 8'h0C, c); send(0, 8'h03, c); send(0, 8'h04, c);
        push_done(0, c, 32'h0C0304);
        idle(0, 2);

        // 3: noise then a packet whose middle byte carries the sync bit
        for (int i = 0; i < 5; i++) send(0, noise[i], c);
        send(0, 8'h08, c); send(0, 8'hFF, c); send(0, 8'hF7, c);
        push_done(0, c, 32'h08FFF7);
        idle(0, 2);

        // 4: timeout after 16 idle cycles, out_bytes held, then the byte-wins case
        send(0, 8'h08, c); send(0, 8'h01, c);
        push_err(0, c + 16, 32'd1);
        idle(0, 16);
        chk("hold_after_timeout", {40'h0, ob0}, {40'h0, 24'h08FFF7});
        chk("cnt_after_timeout", {56'h0, ec0}, 64'd1);
        send(0, 8'h02, c); send(0, 8'h03, c);
        idle(0, 3);
        send(0, 8'h08, c); send(0, 8'h01, c);
        idle(0, 15);
        send(0, 8'h02, c);
        push_done(0, c, 32'h080102);
        idle(0, 20);

        // 5: saturation of a 2-bit error counter
        for (int i = 0; i < 5; i++) begin
            send(1, 8'h08, c);
            push_err(1, c + 16, exp_e[i]);
            idle(1, 16);
        end
        idle(1, 2);

        // 6: asynchronous reset mid-packet
        send(0, 8'h08, c); send(0, 8'h01, c);
        vld[0] = 1'b0;
        send(2, 8'h08, c); send(2, 8'h01, c);
        vld[2] = 1'b0;
        #3 reset = 1'b1;
        #1;
        chk("arst_out0", {40'h0, ob0}, 64'h0);
        chk("arst_cnt0", {56'h0, ec0}, 64'h0);
        chk("arst_cnt1", {62'h0, ec1}, 64'h0);
        chk("arst_out2", {32'h0, ob2}, 64'h0);
        @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        send(0, 8'h55, c); send(0, 8'h08, c); send(0, 8'h09, c); send(0, 8'h0A, c);
        push_done(0, c, 32'h08090A);
        vld[0] = 1'b0;
        send(2, 8'h55, c); send(2, 8'h08, c); send(2, 8'h09, c); send(2, 8'h0A, c); send(2, 8'h0B, c);
        push_done(2, c, 32'h08090A0B);
        idle(2, 3);

        for (int k = 0; k < 3; k++) begin
            chk($sformatf("done_left%0d", k), 64'(dq[k].size()), 64'h0);
            chk($sformatf("timeout_left%0d", k), 64'(eq[k].size()), 64'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
